// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the memory stage
package mem_access_pkg;
  typedef enum logic {ST_IDLE, ST_WAIT} state_e;
endpackage

// File: rtl/mem_access.sv
// mem_access: RV32I memory stage with req/ack data port, branch resolution and MEM/WB register
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       i_pipe_TargetAddr,
  input  logic [31:0]       i_pipe_AluResult,
  input  logic              i_pipe_Zero,
  input  logic [31:0]       i_pipe_Reg2Data,
  input  logic [4:0]        i_pipe_RegDst,
  input  logic              i_pipe_MemToReg,
  input  logic              i_pipe_RegWrEn,
  input  logic              i_pipe_MemWrEn,
  input  logic              i_pipe_Branch,
  input  logic              i_pipe_Jump,
  output logic              o_pipe_PCSrc,
  output logic [31:0]       o_pipe_BranchTarget,
  output logic              o_pipe_Stall,
  output logic              o_dmem_Req,
  output logic              o_dmem_WrEn,
  output logic [ADDR_W-1:0] o_dmem_Addr,
  output logic [31:0]       o_dmem_WrData,
  input  logic              i_dmem_Ack,
  input  logic [31:0]       i_dmem_RdData,
  output logic [31:0]       o_pipe_AluResult,
  output logic [31:0]       o_pipe_MemData,
  output logic [4:0]        o_pipe_RegDst,
  output logic              o_pipe_MemToReg,
  output logic              o_pipe_RegWrEn
);
  state_e      state_q;
  logic [31:0] alu_q, wrdata_q;
  logic [4:0]  rd_q;
  logic        m2r_q, rwe_q, mwe_q;
  logic        in_wait, done;
  logic [31:0] s_alu, s_wrdata;
  logic [4:0]  s_rd;
  logic        s_m2r, s_rwe, s_mwe;

  // Request source: live EX/MEM inputs in IDLE, latched copy while waiting
  always_comb begin
    in_wait  = state_q == ST_WAIT;
    s_alu    = in_wait ? alu_q    : i_pipe_AluResult;
    s_wrdata = in_wait ? wrdata_q : i_pipe_Reg2Data;
    s_rd     = in_wait ? rd_q     : i_pipe_RegDst;
    s_m2r    = in_wait ? m2r_q    : i_pipe_MemToReg;
    s_rwe    = in_wait ? rwe_q    : i_pipe_RegWrEn;
    s_mwe    = in_wait ? mwe_q    : i_pipe_MemWrEn;
    o_dmem_Req    = ~reset & (in_wait | i_pipe_MemToReg | i_pipe_MemWrEn);
    o_dmem_WrEn   = s_mwe;
    o_dmem_Addr   = s_alu[ADDR_W-1:0] & ~ADDR_W'(3);
    o_dmem_WrData = s_wrdata;
    o_pipe_Stall  = o_dmem_Req & ~i_dmem_Ack;
    done          = o_dmem_Req & i_dmem_Ack;
    o_pipe_PCSrc        = (i_pipe_Branch & i_pipe_Zero) | i_pipe_Jump;
    o_pipe_BranchTarget = i_pipe_TargetAddr;
  end

  // FSM: latch the request when memory does not ack on the first cycle, release on ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      alu_q    <= '0;
      wrdata_q <= '0;
      rd_q     <= '0;
      m2r_q    <= 1'b0;
      rwe_q    <= 1'b0;
      mwe_q    <= 1'b0;
    end else if (!in_wait && o_dmem_Req && !i_dmem_Ack) begin
      state_q  <= ST_WAIT;
      alu_q    <= i_pipe_AluResult;
      wrdata_q <= i_pipe_Reg2Data;
      rd_q     <= i_pipe_RegDst;
      m2r_q    <= i_pipe_MemToReg;
      rwe_q    <= i_pipe_RegWrEn;
      mwe_q    <= i_pipe_MemWrEn;
    end else if (in_wait && i_dmem_Ack) begin
      state_q <= ST_IDLE;
    end
  end

  // MEM/WB register: bubble while stalled, load data only on a completed load
  always_ff @(posedge clk) begin
    if (reset || o_pipe_Stall) begin
      o_pipe_AluResult <= '0;
      o_pipe_MemData   <= '0;
      o_pipe_RegDst    <= '0;
      o_pipe_MemToReg  <= 1'b0;
      o_pipe_RegWrEn   <= 1'b0;
    end else begin
      o_pipe_AluResult <= s_alu;
      o_pipe_MemData   <= (done && s_m2r && !s_mwe) ? i_dmem_RdData : '0;
      o_pipe_RegDst    <= s_rd;
      o_pipe_MemToReg  <= s_m2r;
      o_pipe_RegWrEn   <= s_rwe;
    end
  end
endmodule
